// File: rtl/div5.sv
// Sequential 10-bit by 5-bit unsigned restoring divider, one quotient bit per clock.
// Optional DIV5_ZERO_CHECK_EN: divide-by-zero short-circuits to DONE with dz set.
module div5 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] p,
  input  logic [4:0] m,
  output logic [9:0] q,
  output logic [4:0] r,
  output logic       busy,
  output logic       done,
  output logic       dz
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t     state_q, state_d;
  logic [9:0] dvd_q, dvd_d;
  logic [4:0] dvs_q, dvs_d;
  logic [4:0] rem_q, rem_d;
  logic [9:0] quo_q, quo_d;
  logic [3:0] n_q, n_d;
  logic [9:0] q_q, q_d;
  logic [4:0] r_q, r_d;
  logic [5:0] t, diff;

`ifdef DIV5_ZERO_CHECK_EN
  logic dz_q, dz_d;
`endif

  assign t    = {rem_q, dvd_q[9]};
  assign diff = t - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    n_d     = n_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV5_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dvd_d   = p;
          dvs_d   = m;
          rem_d   = 5'd0;
          quo_d   = 10'd0;
          n_d     = 4'd0;
          state_d = StRun;
`ifdef DIV5_ZERO_CHECK_EN
          dz_d = 1'b0;
          if (m == 5'd0) begin
            state_d = StDone;
            q_d     = 10'h3ff;
            r_d     = 5'd0;
            dz_d    = 1'b1;
          end
`endif
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        dvd_d = {dvd_q[8:0], 1'b0};
        if (t >= {1'b0, dvs_q}) begin
          rem_d = diff[4:0];
          quo_d = {quo_q[8:0], 1'b1};
        end else begin
          rem_d = t[4:0];
          quo_d = {quo_q[8:0], 1'b0};
        end
        n_d = n_q + 4'd1;
        // Results are published only on completion so q/r hold through RUN.
        if (n_q == 4'd9) begin
          state_d = StDone;
          q_d     = quo_d;
          r_d     = rem_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= 10'd0;
      dvs_q   <= 5'd0;
      rem_q   <= 5'd0;
      quo_q   <= 10'd0;
      n_q     <= 4'd0;
      q_q     <= 10'd0;
      r_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      n_q     <= n_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

`ifdef DIV5_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= dz_d;
  end
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_div5.sv
// Randomized and directed bench for div5 against an arithmetic reference model.
module tb_div5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] p;
  logic [4:0] m;
  logic [9:0] q;
  logic [4:0] r;
  logic       busy, done, dz;

  int checks = 0;
  int errors = 0;

  div5 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .p    (p),
    .m    (m),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero behaviour of the build.
  task automatic model(input logic [9:0] a, input logic [4:0] b, output logic [9:0] eq,
                       output logic [4:0] er, output logic edz, output int lat);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      eq = 10'h3ff;
`ifdef DIV5_ZERO_CHECK_EN
      er  = 5'd0;
      edz = 1'b1;
      lat = 1;
`else
      er  = 5'(ai % 32);
      edz = 1'b0;
      lat = 11;
`endif
    end else begin
      eq  = 10'(ai / bi);
      er  = 5'(ai % bi);
      edz = 1'b0;
      lat = 11;
    end
  endtask

  // now=1 drives start in the current (DONE) cycle; inj injects an ignored start mid-run.
  task automatic do_div(input logic [9:0] a, input logic [4:0] b, input bit now, input int inj);
    logic [9:0] eq;
    logic [4:0] er;
    logic       edz;
    int         lat, cyc;
    model(a, b, eq, er, edz, lat);
    if (!now) @(negedge clk);
    start = 1'b1;
    p     = a;
    m     = b;
    @(negedge clk);
    start = 1'b0;
    p     = 10'($urandom);
    m     = 5'($urandom);
    cyc   = 1;
    while (done !== 1'b1 && cyc <= 30) begin
      chk("busy_run", 32'(busy), 32'd1);
      if (cyc == inj) begin
        start = 1'b1;
        p     = 10'd50;
        m     = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("q", 32'(q), 32'(eq));
    chk("r", 32'(r), 32'(er));
    chk("dz", 32'(dz), 32'(edz));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    p     = 10'd0;
    m     = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);

    // Reset wins over start in the same cycle.
    start = 1'b1;
    p     = 10'd391;
    m     = 5'd17;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_wins_busy", 32'(busy), 32'd0);

    do_div(10'd391, 5'd17, 1'b0, -1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("q_held", 32'(q), 32'd23);
    do_div(10'd1000, 5'd7, 1'b0, -1);
    do_div(10'd1023, 5'd31, 1'b0, -1);
    do_div(10'd1023, 5'd1, 1'b0, -1);
    do_div(10'd5, 5'd0, 1'b0, -1);

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    do_div(10'd100, 5'd9, 1'b0, 4);
    chk("ignored_q", 32'(q), 32'd11);
    do_div(10'd50, 5'd3, 1'b1, -1);
    chk("b2b_q", 32'(q), 32'd16);

    // Reset in cycle 6 of a run discards it.
    @(negedge clk);
    start = 1'b1;
    p     = 10'd391;
    m     = 5'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    for (int i = 0; i < 15; i++) begin
      chk("no_done_after_rst", 32'(done), 32'd0);
      @(negedge clk);
    end
    do_div(10'd391, 5'd23, 1'b0, -1);

    for (int i = 0; i < 25; i++) begin
      do_div(10'($urandom), 5'($urandom_range(0, 31)), i[0], -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
